// File: rtl/bytecode_fetch.sv
// Bytecode front end: fetches an opcode plus 0..2 inline operand bytes
// from byte-wide synchronous memory and hands the instruction to execute.
module bytecode_fetch #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        opcode,
    input  logic [1:0]        argc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [15:0]       arg,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_OP,
        LAT_OP,
        DEC,
        REQ_ARG,
        LAT_ARG,
        VALID
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        remaining;
    logic              redir_hit;

    assign redir_hit = redirect && (state != IDLE);
    assign mem_rd    = (state == REQ_OP) || (state == REQ_ARG);
    assign mem_addr  = mem_rd ? pc : '0;
    assign ins_valid = (state == VALID);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // stop beats redirect, redirect beats the normal sequence
    always_comb begin
        state_d = state;
        if (stop) begin
            state_d = IDLE;
        end else if (redir_hit) begin
            state_d = REQ_OP;
        end else begin
            unique case (state)
                IDLE:    if (start) state_d = REQ_OP;
                REQ_OP:  state_d = LAT_OP;
                LAT_OP:  state_d = DEC;
                DEC:     state_d = (argc == 2'd0) ? VALID : REQ_ARG;
                REQ_ARG: state_d = LAT_ARG;
                LAT_ARG: state_d = (remaining == 2'd1) ? VALID : REQ_ARG;
                VALID:   if (ins_ready) state_d = REQ_OP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            ins_pc    <= '0;
            arg       <= '0;
            opcode    <= 8'h00;
            remaining <= 2'd0;
        end else if (stop) begin
            pc <= pc;
        end else if (redir_hit) begin
            pc <= redirect_addr;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) pc <= start_addr;
                end
                LAT_OP: begin
                    opcode    <= mem_rdata;
                    ins_pc    <= pc;
                    pc        <= pc + ADDR_W'(1);
                    arg       <= '0;
                    remaining <= 2'd0;
                end
                DEC: begin
                    remaining <= (argc == 2'b11) ? 2'd2 : argc;
                end
                LAT_ARG: begin
                    arg       <= {arg[7:0], mem_rdata};
                    pc        <= pc + ADDR_W'(1);
                    remaining <= remaining - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Directed bench for bytecode_fetch: sequencing, backpressure,
// redirect, wrap-around, stop and async reset.
module tb_bytecode_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // 16-bit address instance
    logic        start, stop, ins_ready, redirect;
    logic [15:0] start_addr, redirect_addr;
    logic        mem_rd, ins_valid, busy;
    logic [15:0] mem_addr, ins_pc, arg;
    logic [7:0]  mem_rdata, opcode;
    logic [1:0]  argc;
    logic [7:0]  mem0 [0:255];

    // 4-bit address instance for wrap checks
    logic        start_w, stop_w, ins_ready_w, redirect_w;
    logic [3:0]  start_addr_w, redirect_addr_w;
    logic        mem_rd_w, ins_valid_w, busy_w;
    logic [3:0]  mem_addr_w, ins_pc_w;
    logic [15:0] arg_w;
    logic [7:0]  mem_rdata_w, opcode_w;
    logic [1:0]  argc_w;
    logic [7:0]  mem1 [0:15];

    function automatic logic [1:0] argc_of(input logic [7:0] op);
        case (op)
            8'h10:   return 2'd1;
            8'h11:   return 2'd2;
            8'ha7:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    assign argc   = argc_of(opcode);
    assign argc_w = argc_of(opcode_w);

    always @(posedge clk) begin
        if (mem_rd)   mem_rdata   <= mem0[mem_addr[7:0]];
        if (mem_rd_w) mem_rdata_w <= mem1[mem_addr_w];
    end

    bytecode_fetch #(.ADDR_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stop(stop), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .opcode(opcode), .argc(argc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_pc(ins_pc),
        .arg(arg), .redirect(redirect), .redirect_addr(redirect_addr),
        .busy(busy)
    );

    bytecode_fetch #(.ADDR_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_w), .start_addr(start_addr_w),
        .stop(stop_w), .mem_rd(mem_rd_w), .mem_addr(mem_addr_w),
        .mem_rdata(mem_rdata_w), .opcode(opcode_w), .argc(argc_w),
        .ins_valid(ins_valid_w), .ins_ready(ins_ready_w), .ins_pc(ins_pc_w),
        .arg(arg_w), .redirect(redirect_w), .redirect_addr(redirect_addr_w),
        .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at the negedge where the DUT sits in REQ_OP; returns at the
    // negedge where ins_valid is first seen.
    task automatic wait_valid(input bit w, input int exp_cyc,
                              input logic [15:0] exp_pc,
                              input logic [7:0] exp_op,
                              input logic [15:0] exp_arg,
                              input string tag);
        int k;
        k = 0;
        while (!(w ? ins_valid_w : ins_valid) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, exp_cyc);
        chk({tag, "_pc"}, w ? {12'h0, ins_pc_w} : ins_pc, exp_pc);
        chk({tag, "_op"}, w ? opcode_w : opcode, exp_op);
        chk({tag, "_arg"}, w ? arg_w : arg, exp_arg);
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
        for (int i = 0; i < 16; i++)  mem1[i] = 8'h00;
        mem0[0] = 8'h04; mem0[1] = 8'h10; mem0[2] = 8'h05;
        mem0[3] = 8'h11; mem0[4] = 8'h12; mem0[5] = 8'h34;
        mem0[8] = 8'ha7; mem0[9] = 8'h00; mem0[10] = 8'h10;
        mem0[8'h20] = 8'h60; mem0[8'h40] = 8'h03;
        mem1[4'hE] = 8'h04; mem1[4'hF] = 8'h10; mem1[4'h0] = 8'h7F;

        rst_n = 1'b0;
        start = 0; stop = 0; ins_ready = 1; redirect = 0;
        start_addr = '0; redirect_addr = '0;
        start_w = 0; stop_w = 0; ins_ready_w = 1; redirect_w = 0;
        start_addr_w = '0; redirect_addr_w = '0;

        repeat (2) @(negedge clk);
        chk("rst_opcode", opcode, 8'h00);
        chk("rst_valid", ins_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_memrd", mem_rd, 1'b0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_pc_arg", {ins_pc, arg}, 32'h0);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd || busy) ok = 1'b0;
        end
        chk("idle_quiet", ok, 1'b1);

        // sequential decode
        start = 1; start_addr = 16'h0;
        @(negedge clk);
        start = 0;
        chk("seq_req", {busy, mem_rd, mem_addr}, {2'b11, 16'h0});
        wait_valid(0, 3, 16'h0, 8'h04, 16'h0000, "seq0");
        @(negedge clk);
        wait_valid(0, 5, 16'h1, 8'h10, 16'h0005, "seq1");
        @(negedge clk);
        wait_valid(0, 7, 16'h3, 8'h11, 16'h1234, "seq2");
        stop = 1;
        @(negedge clk);
        stop = 0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_valid", ins_valid, 1'b0);

        // start and stop together stay idle
        start = 1; stop = 1;
        @(negedge clk);
        start = 0; stop = 0;
        chk("start_stop_idle", busy, 1'b0);

        // backpressure
        ins_ready = 0; start = 1; start_addr = 16'h1;
        @(negedge clk);
        start = 0;
        wait_valid(0, 5, 16'h1, 8'h10, 16'h0005, "bp");
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!ins_valid || mem_rd || opcode !== 8'h10 ||
                arg !== 16'h0005 || ins_pc !== 16'h1) ok = 1'b0;
        end
        chk("bp_stable", ok, 1'b1);
        ins_ready = 1;
        @(negedge clk);
        ins_ready = 0;
        chk("bp_accept", {ins_valid, mem_rd, mem_addr}, {2'b01, 16'h3});
        stop = 1;
        @(negedge clk);
        stop = 0;

        // redirect during LAT_ARG of 0xa7
        ins_ready = 1; start = 1; start_addr = 16'h8;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("redir_in_lat", {mem_rd, ins_valid}, 2'b00);
        redirect = 1; redirect_addr = 16'h20;
        @(negedge clk);
        redirect = 0;
        chk("redir_req", {mem_rd, mem_addr}, {1'b1, 16'h20});
        wait_valid(0, 3, 16'h20, 8'h60, 16'h0000, "redir");

        // redirect coincident with handshake
        redirect = 1; redirect_addr = 16'h40;
        @(negedge clk);
        redirect = 0;
        chk("redir_hs_req", {ins_valid, mem_rd, mem_addr}, {2'b01, 16'h40});
        wait_valid(0, 3, 16'h40, 8'h03, 16'h0000, "redir_hs");
        stop = 1;
        @(negedge clk);
        stop = 0;

        // async reset in REQ_ARG
        start = 1; start_addr = 16'h1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre_rst_reqarg", {mem_rd, mem_addr}, {1'b1, 16'h2});
        rst_n = 0;
        #1;
        chk("arst_now", {opcode, ins_valid, mem_rd, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (mem_rd) ok = 1'b0;
        end
        chk("arst_quiet", ok, 1'b1);

        // 4-bit wrap
        start_w = 1; start_addr_w = 4'hE;
        @(negedge clk);
        start_w = 0;
        wait_valid(1, 3, 16'hE, 8'h04, 16'h0000, "wrap0");
        @(negedge clk);
        wait_valid(1, 5, 16'hF, 8'h10, 16'h007F, "wrap1");
        @(negedge clk);
        chk("wrap_pc", {mem_rd_w, mem_addr_w}, {1'b1, 4'h1});
        stop_w = 1;
        @(negedge clk);
        stop_w = 0;
        chk("wrap_stop", busy_w, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
